adc_volt_proc: RTL and testbench

//   Downstream of the PCF8591 controller, upstream of seg_led. Takes each raw 8-bit
//   ADC byte (one-cycle strobe) and block-averages 2^AVG_SHIFT samples.

---
 rtl/adc_volt_proc.sv | 137 +++++++++++++
 tb/tb_adc_volt_proc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_volt_proc.sv
// adc_volt_proc: block-averages raw ADC bytes and scales the average to millivolts.
// Optional peak hold is enabled with `define PEAK_HOLD_EN (adds peak_clr / peak_mv).
module adc_volt_proc #(
    parameter int          AVG_SHIFT = 3,
    parameter logic [15:0] VREF_MV   = 16'd3300
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ad_data,
    input  logic        ad_valid,
    output logic [19:0] num,
    output logic        num_valid,
`ifdef PEAK_HOLD_EN
    input  logic        peak_clr,
    output logic [19:0] peak_mv,
`endif
    output logic        ovr
);

    localparam int AW = 8 + AVG_SHIFT;
    localparam int CW = (AVG_SHIFT > 0) ? AVG_SHIFT : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_SHIFT) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_sum;
    logic [CW-1:0] cnt;
    logic          blk_end;
    logic          blk_rdy;
    logic [7:0]    blk_avg;
    logic [7:0]    avg;
    logic [2:0]    mul_cnt;
    logic [23:0]   prod;
    logic [23:0]   addend;
    logic [19:0]   num_new;

    assign acc_sum = acc + AW'(ad_data);
    assign blk_end = ad_valid && (cnt == CNT_LAST);
    assign addend  = avg[mul_cnt] ? (24'(VREF_MV) << mul_cnt) : 24'd0;
    assign num_new = {4'd0, prod[23:8]};

    // Accumulator keeps running in every state; a finished block is
    // staged for one cycle so the FSM sees it as a single-cycle request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            blk_rdy <= 1'b0;
            blk_avg <= 8'd0;
        end else begin
            blk_rdy <= blk_end;
            if (blk_end) begin
                acc     <= '0;
                cnt     <= '0;
                blk_avg <= 8'(acc_sum >> AVG_SHIFT);
            end else if (ad_valid) begin
                acc <= acc_sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (blk_rdy) state_nxt = MUL;
            MUL:     if (mul_cnt == 3'd7) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg       <= 8'd0;
            prod      <= 24'd0;
            mul_cnt   <= 3'd0;
            num       <= 20'd0;
            num_valid <= 1'b0;
            ovr       <= 1'b0;
        end else begin
            num_valid <= 1'b0;
            if (blk_rdy && (state != IDLE)) begin
                ovr <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (blk_rdy) begin
                        avg     <= blk_avg;
                        prod    <= 24'd0;
                        mul_cnt <= 3'd0;
                    end
                end
                MUL: begin
                    prod    <= prod + addend;
                    mul_cnt <= mul_cnt + 3'd1;
                end
                DONE: begin
                    num       <= num_new;
                    num_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PEAK_HOLD_EN
    // A clear coinciding with DONE restarts the peak at the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_mv <= 20'd0;
        end else if (state == DONE) begin
            if (peak_clr || (num_new > peak_mv)) begin
                peak_mv <= num_new;
            end
        end else if (peak_clr) begin
            peak_mv <= 20'd0;
        end
    end
`endif

endmodule

// File: tb/tb_adc_volt_proc.sv
// tb_adc_volt_proc: table-driven and scoreboard checks of adc_volt_proc
// for AVG_SHIFT=3 (dut) and AVG_SHIFT=0 (dut0).
module tb_adc_volt_proc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [7:0]  ad_data, ad_data0;
    logic        ad_valid, ad_valid0;
    logic [19:0] num, num0;
    logic        num_valid, num_valid0;
    logic        ovr, ovr0;
`ifdef PEAK_HOLD_EN
    logic        peak_clr, peak_clr0;
    logic [19:0] peak_mv, peak_mv0;
`endif

    adc_volt_proc #(.AVG_SHIFT(3), .VREF_MV(16'd3300)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ad_data   (ad_data),
        .ad_valid  (ad_valid),
        .num       (num),
        .num_valid (num_valid),
`ifdef PEAK_HOLD_EN
        .peak_clr  (peak_clr),
        .peak_mv   (peak_mv),
`endif
        .ovr       (ovr)
    );

    adc_volt_proc #(.AVG_SHIFT(0), .VREF_MV(16'd3300)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ad_data   (ad_data0),
        .ad_valid  (ad_valid0),
        .num       (num0),
        .num_valid (num_valid0),
`ifdef PEAK_HOLD_EN
        .peak_clr  (peak_clr0),
        .peak_mv   (peak_mv0),
`endif
        .ovr       (ovr0)
    );

    typedef struct {
        logic [63:0] d;
        logic [19:0] e;
    } vec_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pc = 0, pc0 = 0;
    int last_pc = 0, last_pc0 = 0;
    logic [19:0] q[$];
    logic [19:0] q0[$];
    logic nv_d = 1'b0, nv0_d = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (num_valid) begin
            pc++;
            last_pc = cyc;
            chk("pulse_expected", int'(q.size() > 0), 1);
            if (q.size() > 0) chk("num", int'(num), int'(q.pop_front()));
            chk("num_valid_width", int'(nv_d), 0);
        end
        nv_d <= num_valid;
    end

    always @(negedge clk) begin
        if (num_valid0) begin
            pc0++;
            last_pc0 = cyc;
            chk("pulse0_expected", int'(q0.size() > 0), 1);
            if (q0.size() > 0) chk("num0", int'(num0), int'(q0.pop_front()));
            chk("num_valid0_width", int'(nv0_d), 0);
        end
        nv0_d <= num_valid0;
    end

    // gap=0 gives strobes on consecutive cycles; t_last is the sampling edge
    task automatic burst(input logic [63:0] d, input int n, input int gap,
                         output int t_last);
        t_last = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ad_data  = d[(i % 8) * 8 +: 8];
            ad_valid = 1'b1;
            t_last   = cyc + 1;
            if (gap > 0) begin
                @(negedge clk);
                ad_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        if (gap == 0) begin
            @(negedge clk);
            ad_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ad_valid  = 1'b0;
        ad_valid0 = 1'b0;
        q.delete();
        q0.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t tbl[8];
        int t0, t1, p;
        tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 20'd3287};
        tbl[1] = '{64'h8080_8080_0000_0000, 20'd825};
        tbl[2] = '{64'h8080_8080_8080_8080, 20'd1650};
        tbl[3] = '{64'h0000_0000_0000_0000, 20'd0};
        tbl[4] = '{64'h0807_0605_0403_0201, 20'd51};
        tbl[5] = '{64'h0700_0000_0000_0000, 20'd0};
        tbl[6] = '{64'h6464_6464_6464_6464, 20'd1289};
        tbl[7] = '{64'h7F7F_7F7F_7F7F_7F7F, 20'd1637};

        rst_n = 1'b0;
        ad_data = 8'd0;
        ad_valid = 1'b0;
        ad_data0 = 8'd0;
        ad_valid0 = 1'b0;
`ifdef PEAK_HOLD_EN
        peak_clr = 1'b0;
        peak_clr0 = 1'b0;
`endif
        repeat (4) @(negedge clk);
        chk("rst_num", int'(num), 0);
        chk("rst_num_valid", int'(num_valid), 0);
        chk("rst_ovr", int'(ovr), 0);
        chk("rst_ovr0", int'(ovr0), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_num_valid", int'(num_valid), 0);
        chk("post_rst_pulses", pc, 0);

        // AVG_SHIFT=0: two strobes back to back, second one is dropped
        q0.push_back(20'd1289);
        @(negedge clk);
        ad_data0 = 8'd100;
        ad_valid0 = 1'b1;
        t0 = cyc + 1;
        @(negedge clk);
        ad_data0 = 8'd200;
        @(negedge clk);
        ad_valid0 = 1'b0;
        repeat (20) @(negedge clk);
        chk("s0_pulses", pc0, 1);
        chk("s0_latency", last_pc0 - t0, 10);
        chk("s0_ovr", int'(ovr0), 1);

        for (int i = 0; i < 8; i++) begin
            p = pc;
            q.push_back(tbl[i].e);
            burst(tbl[i].d, 8, 2, t0);
            repeat (14) @(negedge clk);
            chk($sformatf("row%0d_pulses", i), pc - p, 1);
            chk($sformatf("row%0d_latency", i), last_pc - t0, 10);
            chk($sformatf("row%0d_ovr", i), int'(ovr), 0);
        end

        p = pc;
        burst(64'h0, 7, 2, t0);
        repeat (20) @(negedge clk);
        chk("seven_no_pulse", pc - p, 0);
        q.push_back(20'd0);
        burst(64'h0, 1, 2, t0);
        repeat (14) @(negedge clk);
        chk("eighth_pulse", pc - p, 1);
        chk("eighth_latency", last_pc - t0, 10);

        // final strobes 9 cycles apart: second block dropped
        p = pc;
        q.push_back(20'd3287);
        burst(tbl[0].d, 8, 0, t0);
        burst(tbl[2].d, 8, 0, t1);
        repeat (20) @(negedge clk);
        chk("gap9_pulses", pc - p, 1);
        chk("gap9_ovr", int'(ovr), 1);

        // final strobes 10 cycles apart: both accepted
        p = pc;
        q.push_back(20'd1650);
        burst(tbl[2].d, 8, 0, t0);
        @(negedge clk);
        q.push_back(20'd0);
        burst(tbl[3].d, 8, 0, t1);
        repeat (20) @(negedge clk);
        chk("gap10_pulses", pc - p, 2);
        chk("gap10_latency", last_pc - t1, 10);
        chk("ovr_sticky", int'(ovr), 1);

        do_reset();
        chk("rst_clears_ovr", int'(ovr), 0);

        // reset mid-multiply with a partially filled accumulator
        p = pc;
        burst(tbl[0].d, 8, 0, t0);
        burst(tbl[0].d, 3, 0, t1);
        @(negedge clk);
        do_reset();
        chk("mid_rst_num", int'(num), 0);
        repeat (15) @(negedge clk);
        chk("mid_rst_no_pulse", pc - p, 0);
        q.push_back(20'd1650);
        burst(tbl[2].d, 8, 2, t0);
        repeat (14) @(negedge clk);
        chk("mid_rst_restart", pc - p, 1);
        chk("mid_rst_latency", last_pc - t0, 10);

`ifdef PEAK_HOLD_EN
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        chk("peak_clr_a", int'(peak_mv), 0);
        q.push_back(20'd825);
        burst(tbl[1].d, 8, 2, t0);
        repeat (14) @(negedge clk);
        q.push_back(20'd3287);
        burst(tbl[0].d, 8, 2, t0);
        repeat (14) @(negedge clk);
        q.push_back(20'd1289);
        burst(tbl[6].d, 8, 2, t0);
        repeat (14) @(negedge clk);
        chk("peak_hold", int'(peak_mv), 3287);
        @(negedge clk);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        chk("peak_clr_b", int'(peak_mv), 0);
        q.push_back(20'd1289);
        burst(tbl[6].d, 8, 2, t0);
        repeat (14) @(negedge clk);
        chk("peak_after_clr", int'(peak_mv), 1289);
`endif

        chk("sb_drained", q.size(), 0);
        chk("sb0_drained", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
